tdc_pattern_checker: RTL and testbench
======================================

# tdc_pattern_checker

Receive-side checker for the 30-bit TDC test-pattern word `{pixelID[7:0], BCID[11:0], counter[8:0], hit}`, placed after the readout path to confirm that generated test data arrives intact. It locks to the incoming BCID sequence and compares every subsequent valid word against a locally predicted BCID, the configured pixel ID, and a tracked L1A hit counter. It reports lock status, a saturating error count and per-field error pulses to slow control.

## Interface
Parameters:
- `LOCK_COUNT`, 8: consecutive consistent words required to enter LOCKED.
- `MISS_LIMIT`, 4: consecutive BCID/pixel mismatches that drop LOCKED back to SEARCH.
- `BCID_MAX`, 3563: last BCID value before wrap to 0.

Ports:
- `clk`, in, 1: 40 MHz clock.
- `reset`, in, 1: reset, asynchronous, active-high.
- `enable`, in, 1: 0 forces IDLE.
- `mode`, in, 1: 0 = counter field must always be 9'h1AA; 1 = L1A counter tracking.
- `pixelID`, in, 8: expected pixel ID.
- `din`, in, 30: received pattern word.
- `dinValid`, in, 1: `din` is a valid word this cycle.
- `clearErr`, in, 1: synchronous clear of `errCount` and `hitCount`.
- `locked`, out, 1: checker is in LOCKED.
- `errCount`, out, 16: saturating count of erroneous words while LOCKED.
- `bcidErr`, out, 1: one-cycle pulse on BCID mismatch.
- `pixelErr`, out, 1: one-cycle pulse on pixel ID mismatch.
- `cntErr`, out, 1: one-cycle pulse on counter/hit field mismatch.
- `hitCount`, out, 16: saturating count of words with hit = 1.

## Operation
- States and transitions:
  - IDLE: entered when `enable` = 0 from any state. IDLE → SEARCH when `enable` = 1.
  - SEARCH:
    - First valid word loads `expBCID` = next(BCID field), sets `expCnt` = 0, sets `good` = 1.
    - Each following valid word whose BCID equals `expBCID` and whose pixel field equals `pixelID` increments `good`.
    - Any mismatch reloads from that word and sets `good` = 1.
    - `good` == `LOCK_COUNT` → LOCKED.
  - LOCKED: checks every valid word.
    - `MISS_LIMIT` consecutive words with a BCID or pixel error → SEARCH.
    - Any fully correct word clears the miss counter.
- BCID prediction: next(x) = (x == `BCID_MAX`) ? 0 : x + 1.
  - `expBCID` advances on every `clk` while not IDLE, whether or not the word is valid, because the generator's BCID free-runs.
  - After a BCID mismatch in LOCKED, `expBCID` is not resynchronised.
- Counter check (LOCKED only):
  - hit = 0 → counter must be 9'h1AA.
  - mode = 0 → counter must be 9'h1AA.
  - mode = 1 and hit = 1:
    - counter == `expCnt` → match; `expCnt` ← `expCnt` + 1 mod 512.
    - Else counter == 9'h1AA → match (no L1A); `expCnt` unchanged.
    - Else → `cntErr`.
- `errCount` increments by 1 per valid LOCKED word with any error, and saturates at 16'hFFFF.
- `hitCount` increments per valid word with hit = 1 in SEARCH or LOCKED, and saturates.
- `clearErr` takes priority over a same-cycle increment; the counter reads 0 the next cycle.
- `dinValid` = 0: no checks, no pulses, no state change. `expBCID` still advances.
- Reset mid-operation returns to IDLE immediately; every output reads 0.

## Timing
- Reset values: state IDLE; `locked`, `bcidErr`, `pixelErr`, `cntErr` = 0; `errCount`, `hitCount` = 0; `expBCID`, `expCnt` = 0.
- Two-stage pipeline:
  - Stage 1 registers `din`/`dinValid`.
  - Stage 2 compares and registers the error pulses and counters.
  - Error pulses appear 2 cycles after the offending word is sampled.
- `locked` rises on the cycle the `LOCK_COUNT`-th consistent word's compare registers. It falls on the cycle the `MISS_LIMIT`-th miss registers.
- `enable` falling: state is IDLE on the next edge; pulses in flight are suppressed.

## Configuration
- `TDC_CHECKER_HIT_STATS_EN` defined: `hitCount` logic is present as above.
- Undefined: `hitCount` is tied to 0 and no counter flops are built. All other behaviour is identical.

## Structure
- `commonDefinition.v` gains:
  - Field-position constants: `PIX_MSB`/`LSB`, `BCID_MSB`/`LSB`, `CNT_MSB`/`LSB`, `HIT_BIT`.
  - `NO_L1A_MARKER` (9'h1AA).
  - State encodings.
- One sub-module: `tdc_checker_bcid_tracker`. It holds the `expBCID` register, the wrap logic and a load-from-word input.

## Test plan
- Clean stream: BCID 3560→3563→0→5, pixelID 8'h3C, hit = 0, counter 9'h1AA → `locked` = 1 after 8 words, `errCount` = 0 across the wrap.
- BCID skip: LOCKED, one word carries BCID + 2 → `bcidErr` pulses once, `errCount` = 1, `locked` stays 1.
- Pixel loss of lock: 4 consecutive words with pixelID 8'h3D → 4 `pixelErr` pulses, `locked` = 0, relock after 8 good words.
- mode = 1, hits with counters 0, 1, 9'h1AA, 2 → no errors. A following counter of 7 → `cntErr`, `errCount` increments.
- hit = 0 with counter 9'h005 → `cntErr`. `clearErr` in the same cycle as an error increment → `errCount` = 0.
- Async reset asserted mid-LOCKED → all outputs 0 without a clock edge. Stream resumes → relock after 8 words.

Source files
------------

// File: rtl/tdc_pattern_checker_pkg.sv
// Shared field positions, widths, state encodings and BCID wrap helper for the
// TDC test-pattern checker.
package tdc_pattern_checker_pkg;

    localparam int unsigned WORD_W   = 30;
    localparam int unsigned PIX_W    = 8;
    localparam int unsigned BCID_W   = 12;
    localparam int unsigned CNT_W    = 9;
    localparam int unsigned STAT_W   = 16;

    localparam int unsigned PIX_MSB  = 29;
    localparam int unsigned PIX_LSB  = 22;
    localparam int unsigned BCID_MSB = 21;
    localparam int unsigned BCID_LSB = 10;
    localparam int unsigned CNT_MSB  = 9;
    localparam int unsigned CNT_LSB  = 1;
    localparam int unsigned HIT_BIT  = 0;

    localparam logic [CNT_W-1:0] NO_L1A_MARKER = 9'h1AA;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEARCH = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    typedef struct packed {
        logic [PIX_W-1:0]  pix;
        logic [BCID_W-1:0] bcid;
        logic [CNT_W-1:0]  cnt;
        logic              hit;
    } tdc_word_t;

    // Free-running bunch-crossing successor with wrap after max
    function automatic logic [BCID_W-1:0] bcid_next(input logic [BCID_W-1:0] x,
                                                    input logic [BCID_W-1:0] max);
        return (x == max) ? '0 : x + BCID_W'(1);
    endfunction

endpackage

// File: rtl/tdc_checker_bcid_tracker.sv
// Expected-BCID register: loads next(word) on resync, free-runs otherwise,
// and parks at zero while the checker is idle.
module tdc_checker_bcid_tracker
    import tdc_pattern_checker_pkg::*;
#(
    parameter int unsigned BCID_MAX = 3563
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              load,
    input  logic [BCID_W-1:0] load_bcid,
    output logic [BCID_W-1:0] exp_bcid
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_bcid <= '0;
        end else if (load) begin
            exp_bcid <= bcid_next(load_bcid, BCID_W'(BCID_MAX));
        end else if (run) begin
            exp_bcid <= bcid_next(exp_bcid, BCID_W'(BCID_MAX));
        end else begin
            exp_bcid <= '0;
        end
    end

endmodule

// File: rtl/tdc_pattern_checker.sv
// Receive-side TDC test-pattern checker: locks to the BCID sequence, then checks
// BCID, pixel ID and L1A counter. Hit statistics built when TDC_CHECKER_HIT_STATS_EN.
module tdc_pattern_checker
    import tdc_pattern_checker_pkg::*;
#(
    parameter int unsigned LOCK_COUNT = 8,
    parameter int unsigned MISS_LIMIT = 4,
    parameter int unsigned BCID_MAX   = 3563
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              mode,
    input  logic [PIX_W-1:0]  pixelID,
    input  logic [WORD_W-1:0] din,
    input  logic              dinValid,
    input  logic              clearErr,
    output logic              locked,
    output logic [STAT_W-1:0] errCount,
    output logic              bcidErr,
    output logic              pixelErr,
    output logic              cntErr,
    output logic [STAT_W-1:0] hitCount
);

    localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned MISS_W = $clog2(MISS_LIMIT + 1);

    logic [1:0]        state, state_n;
    logic [GOOD_W-1:0] good, good_n;
    logic [MISS_W-1:0] miss, miss_n;
    logic [CNT_W-1:0]  exp_cnt, exp_cnt_n;
    logic [STAT_W-1:0] err_n;
    logic              bcid_err_n, pix_err_n, cnt_err_n, locked_n;
    logic              bcid_bad, pix_bad, cnt_bad, load_c, run_c;
    logic [BCID_W-1:0] exp_bcid;
    tdc_word_t         din_word_c, d1;
    logic              v1;

    assign din_word_c = '{pix:  din[PIX_MSB:PIX_LSB],
                          bcid: din[BCID_MSB:BCID_LSB],
                          cnt:  din[CNT_MSB:CNT_LSB],
                          hit:  din[HIT_BIT]};

    assign run_c = enable && (state != ST_IDLE);

    tdc_checker_bcid_tracker #(
        .BCID_MAX (BCID_MAX)
    ) u_bcid_tracker (
        .clk       (clk),
        .reset     (reset),
        .run       (run_c),
        .load      (load_c),
        .load_bcid (d1.bcid),
        .exp_bcid  (exp_bcid)
    );

    // Stage 1: capture incoming word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d1 <= '0;
            v1 <= 1'b0;
        end else begin
            d1 <= din_word_c;
            v1 <= dinValid;
        end
    end

    // Stage 2 next-state: compare, lock tracking and error pulses
    always_comb begin
        state_n    = state;
        good_n     = good;
        miss_n     = miss;
        exp_cnt_n  = exp_cnt;
        bcid_err_n = 1'b0;
        pix_err_n  = 1'b0;
        cnt_err_n  = 1'b0;
        cnt_bad    = 1'b0;
        load_c     = 1'b0;
        bcid_bad   = (d1.bcid != exp_bcid);
        pix_bad    = (d1.pix != pixelID);

        if (!enable) begin
            state_n = ST_IDLE;
            good_n  = '0;
            miss_n  = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_n = ST_SEARCH;
                    good_n  = '0;
                    miss_n  = '0;
                end
                ST_SEARCH: begin
                    if (v1) begin
                        if (good == '0 || bcid_bad || pix_bad) begin
                            load_c    = 1'b1;
                            exp_cnt_n = '0;
                            good_n    = GOOD_W'(1);
                        end else begin
                            good_n = good + GOOD_W'(1);
                        end
                        if (good_n == GOOD_W'(LOCK_COUNT)) begin
                            state_n = ST_LOCKED;
                            miss_n  = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (v1) begin
                        // A counter equal to the marker on a hit means no L1A was taken
                        if (mode && d1.hit) begin
                            if (d1.cnt == exp_cnt) begin
                                exp_cnt_n = exp_cnt + CNT_W'(1);
                            end else if (d1.cnt != NO_L1A_MARKER) begin
                                cnt_bad = 1'b1;
                            end
                        end else begin
                            cnt_bad = (d1.cnt != NO_L1A_MARKER);
                        end
                        bcid_err_n = bcid_bad;
                        pix_err_n  = pix_bad;
                        cnt_err_n  = cnt_bad;
                        if (bcid_bad || pix_bad) begin
                            if (miss == MISS_W'(MISS_LIMIT - 1)) begin
                                state_n = ST_SEARCH;
                                good_n  = '0;
                                miss_n  = '0;
                            end else begin
                                miss_n = miss + MISS_W'(1);
                            end
                        end else if (!cnt_bad) begin
                            miss_n = '0;
                        end
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end

        locked_n = (state_n == ST_LOCKED);

        err_n = errCount;
        if (clearErr) begin
            err_n = '0;
        end else if ((bcid_err_n || pix_err_n || cnt_err_n) && errCount != 16'hFFFF) begin
            err_n = errCount + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            good     <= '0;
            miss     <= '0;
            exp_cnt  <= '0;
            locked   <= 1'b0;
            errCount <= '0;
            bcidErr  <= 1'b0;
            pixelErr <= 1'b0;
            cntErr   <= 1'b0;
        end else begin
            state    <= state_n;
            good     <= good_n;
            miss     <= miss_n;
            exp_cnt  <= exp_cnt_n;
            locked   <= locked_n;
            errCount <= err_n;
            bcidErr  <= bcid_err_n;
            pixelErr <= pix_err_n;
            cntErr   <= cnt_err_n;
        end
    end

`ifdef TDC_CHECKER_HIT_STATS_EN
    logic hit_inc_c;
    assign hit_inc_c = enable && v1 && d1.hit && (state == ST_SEARCH || state == ST_LOCKED);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hitCount <= '0;
        end else if (clearErr) begin
            hitCount <= '0;
        end else if (hit_inc_c && hitCount != 16'hFFFF) begin
            hitCount <= hitCount + STAT_W'(1);
        end
    end
`else
    assign hitCount = '0;
`endif

endmodule

// File: tb/tb_tdc_pattern_checker.sv
// Directed bench for tdc_pattern_checker: lock, BCID wrap, field errors,
// loss of lock, L1A counter tracking, clear priority, async reset and enable.
module tb_tdc_pattern_checker;

    logic        clk = 1'b0;
    logic        reset, enable, mode, clearErr, dinValid;
    logic [7:0]  pixelID;
    logic [29:0] din;
    logic        locked, bcidErr, pixelErr, cntErr;
    logic [15:0] errCount, hitCount;

    int vectors     = 0;
    int miscompares = 0;
    int g;
    int n_bcid, n_pix, n_cnt;
    int exp_hits;

    always #5 clk = ~clk;

    tdc_pattern_checker dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .mode     (mode),
        .pixelID  (pixelID),
        .din      (din),
        .dinValid (dinValid),
        .clearErr (clearErr),
        .locked   (locked),
        .errCount (errCount),
        .bcidErr  (bcidErr),
        .pixelErr (pixelErr),
        .cntErr   (cntErr),
        .hitCount (hitCount)
    );

    function automatic int bcid_after(input int x);
        return (x == 3563) ? 0 : x + 1;
    endfunction

    // One generator cycle: word carries current BCID (+off), generator BCID always advances
    task automatic gen(input logic [7:0] pix, input int off, input logic [8:0] cnt,
                       input logic hit, input logic v);
        int b;
        b = g;
        for (int k = 0; k < off; k++) b = bcid_after(b);
        din      = {pix, 12'(b), cnt, hit};
        dinValid = v;
        @(posedge clk);
        #1;
        g = bcid_after(g);
        n_bcid += int'(bcidErr);
        n_pix  += int'(pixelErr);
        n_cnt  += int'(cntErr);
    endtask

    task automatic good();
        gen(8'h3C, 0, 9'h1AA, 1'b0, 1'b1);
    endtask

    task automatic clr_counts();
        n_bcid = 0;
        n_pix  = 0;
        n_cnt  = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; mode = 1'b0; clearErr = 1'b0;
        pixelID = 8'h3C; din = '0; dinValid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL reset_locked: got %b want 0", locked); end
        vectors++; if (errCount !== 16'd0) begin miscompares++; $display("FAIL reset_errCount: got %0d want 0", errCount); end
        vectors++; if ({bcidErr, pixelErr, cntErr} !== 3'b000) begin miscompares++; $display("FAIL reset_pulses: got %b want 000", {bcidErr, pixelErr, cntErr}); end
        vectors++; if (hitCount !== 16'd0) begin miscompares++; $display("FAIL reset_hitCount: got %0d want 0", hitCount); end
        reset = 1'b0;
        g = 3559;
        gen(8'h3C, 0, 9'h1AA, 1'b0, 1'b0);
    endtask

    task automatic test_clean_lock();
        clr_counts();
        for (int i = 0; i < 8; i++) good();
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL clean_prelock: got %b want 0", locked); end
        good();
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL clean_lock: got %b want 1", locked); end
        for (int i = 0; i < 4; i++) good();
        vectors++; if (errCount !== 16'd0) begin miscompares++; $display("FAIL clean_wrap_err: got %0d want 0", errCount); end
        vectors++; if (n_bcid + n_pix + n_cnt !== 0) begin miscompares++; $display("FAIL clean_wrap_pulses: got %0d want 0", n_bcid + n_pix + n_cnt); end
    endtask

    task automatic test_bcid_skip();
        clr_counts();
        gen(8'h3C, 2, 9'h1AA, 1'b0, 1'b1);
        good();
        vectors++; if ({bcidErr, pixelErr, cntErr} !== 3'b100) begin miscompares++; $display("FAIL skip_pulse: got %b want 100", {bcidErr, pixelErr, cntErr}); end
        vectors++; if (errCount !== 16'd1) begin miscompares++; $display("FAIL skip_err: got %0d want 1", errCount); end
        good();
        vectors++; if (bcidErr !== 1'b0) begin miscompares++; $display("FAIL skip_one_cycle: got %b want 0", bcidErr); end
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL skip_locked: got %b want 1", locked); end
        good();
        vectors++; if (n_bcid !== 1) begin miscompares++; $display("FAIL skip_count: got %0d want 1", n_bcid); end
    endtask

    task automatic test_pixel_lol();
        clr_counts();
        for (int i = 0; i < 4; i++) gen(8'h3D, 0, 9'h1AA, 1'b0, 1'b1);
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL pix_third_miss: got %b want 1", locked); end
        good();
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL pix_unlock: got %b want 0", locked); end
        vectors++; if (n_pix !== 4) begin miscompares++; $display("FAIL pix_pulses: got %0d want 4", n_pix); end
        vectors++; if (errCount !== 16'd5) begin miscompares++; $display("FAIL pix_err: got %0d want 5", errCount); end
        for (int i = 0; i < 7; i++) good();
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL pix_prerelock: got %b want 0", locked); end
        good();
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL pix_relock: got %b want 1", locked); end
        vectors++; if (errCount !== 16'd5) begin miscompares++; $display("FAIL pix_search_err: got %0d want 5", errCount); end
    endtask

    task automatic test_mode1();
        mode = 1'b1;
        clearErr = 1'b1;
        good();
        clearErr = 1'b0;
        vectors++; if (errCount !== 16'd0) begin miscompares++; $display("FAIL m1_clear: got %0d want 0", errCount); end
        clr_counts();
        gen(8'h3C, 0, 9'd0,   1'b1, 1'b1);
        gen(8'h3C, 0, 9'd1,   1'b1, 1'b1);
        gen(8'h3C, 0, 9'h1AA, 1'b1, 1'b1);
        gen(8'h3C, 0, 9'd2,   1'b1, 1'b1);
        good();
        vectors++; if (n_cnt !== 0 || errCount !== 16'd0) begin miscompares++; $display("FAIL m1_track: cnt pulses %0d err %0d want 0 0", n_cnt, errCount); end
        gen(8'h3C, 0, 9'd7, 1'b1, 1'b1);
        good();
        vectors++; if ({bcidErr, pixelErr, cntErr} !== 3'b001) begin miscompares++; $display("FAIL m1_bad_cnt: got %b want 001", {bcidErr, pixelErr, cntErr}); end
        vectors++; if (errCount !== 16'd1) begin miscompares++; $display("FAIL m1_err: got %0d want 1", errCount); end
        good();
`ifdef TDC_CHECKER_HIT_STATS_EN
        exp_hits = 5;
`else
        exp_hits = 0;
`endif
        vectors++; if (hitCount !== 16'(exp_hits)) begin miscompares++; $display("FAIL m1_hits: got %0d want %0d", hitCount, exp_hits); end
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL m1_locked: got %b want 1", locked); end
    endtask

    task automatic test_hit0_clear();
        gen(8'h3C, 0, 9'h005, 1'b0, 1'b1);
        clearErr = 1'b1;
        good();
        clearErr = 1'b0;
        vectors++; if (cntErr !== 1'b1) begin miscompares++; $display("FAIL hit0_cnt: got %b want 1", cntErr); end
        vectors++; if (errCount !== 16'd0) begin miscompares++; $display("FAIL clear_priority: got %0d want 0", errCount); end
        vectors++; if (hitCount !== 16'd0) begin miscompares++; $display("FAIL clear_hits: got %0d want 0", hitCount); end
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL hit0_locked: got %b want 1", locked); end
    endtask

    task automatic test_async_reset();
        gen(8'h3C, 2, 9'h1AA, 1'b0, 1'b1);
        good();
        vectors++; if (bcidErr !== 1'b1 || errCount !== 16'd1) begin miscompares++; $display("FAIL ar_setup: bcidErr %b err %0d want 1 1", bcidErr, errCount); end
        reset = 1'b1;
        #2;
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL ar_locked: got %b want 0", locked); end
        vectors++; if (errCount !== 16'd0) begin miscompares++; $display("FAIL ar_err: got %0d want 0", errCount); end
        vectors++; if ({bcidErr, pixelErr, cntErr} !== 3'b000) begin miscompares++; $display("FAIL ar_pulses: got %b want 000", {bcidErr, pixelErr, cntErr}); end
        vectors++; if (hitCount !== 16'd0) begin miscompares++; $display("FAIL ar_hits: got %0d want 0", hitCount); end
        #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) good();
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL ar_prerelock: got %b want 0", locked); end
        good();
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL ar_relock: got %b want 1", locked); end
    endtask

    task automatic test_enable();
        gen(8'h3D, 0, 9'h1AA, 1'b0, 1'b1);
        enable = 1'b0;
        good();
        vectors++; if (pixelErr !== 1'b0) begin miscompares++; $display("FAIL en_suppress: got %b want 0", pixelErr); end
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL en_idle: got %b want 0", locked); end
        vectors++; if (errCount !== 16'd0) begin miscompares++; $display("FAIL en_err: got %0d want 0", errCount); end
        enable = 1'b1;
        good();
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL en_search: got %b want 0", locked); end
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_bcid_skip();
        test_pixel_lol();
        test_mode1();
        test_hit0_clear();
        test_async_reset();
        test_enable();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
